// File: rtl/pipelined_ripple_adder.sv
// Pipelined ripple-carry adder/subtractor: WIDTH bits split into STAGES equal segments,
// one register per segment, global-advance valid/ready handshake.
module pipelined_ripple_adder #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned CHUNK = WIDTH / STAGES;

   logic             adv;
   logic [WIDTH-1:0] bb;
   logic             c0;

   logic [STAGES-1:0] vld_q;
   logic [STAGES-1:0] cy_q;
   logic [WIDTH-1:0]  sum_q [STAGES];
   logic [WIDTH-1:0]  opa_q [STAGES];
   logic [WIDTH-1:0]  opb_q [STAGES];
   logic              cmsb_q;

   assign adv      = ~vld_q[STAGES-1] | out_ready;
   assign in_ready = adv;
   assign bb       = sub ? ~b : b;
   assign c0       = sub ? ~cin : cin;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int unsigned Lo = k * CHUNK;

      logic [WIDTH-1:0] sa, sb, ss, sum_d;
      logic             ci, vi;
      logic [CHUNK-1:0] p, g;
      logic [CHUNK:0]   c;

      if (k == 0) begin : g_first
         assign sa = a;
         assign sb = bb;
         assign ss = '0;
         assign ci = c0;
         assign vi = in_valid;
      end else begin : g_next
         assign sa = opa_q[k-1];
         assign sb = opb_q[k-1];
         assign ss = sum_q[k-1];
         assign ci = cy_q[k-1];
         assign vi = vld_q[k-1];
      end

      assign p    = sa[Lo +: CHUNK] ^ sb[Lo +: CHUNK];
      assign g    = sa[Lo +: CHUNK] & sb[Lo +: CHUNK];
      assign c[0] = ci;

      for (genvar i = 0; i < CHUNK; i++) begin : g_bit
         assign c[i+1] = g[i] | (p[i] & c[i]);
      end

      always_comb begin
         sum_d              = ss;
         sum_d[Lo +: CHUNK] = p ^ c[CHUNK-1:0];
      end

      // Operand bits ride along with their own operation so later segments see skewed data.
      always_ff @(posedge clk) begin
         if (rst) begin
            vld_q[k] <= 1'b0;
            cy_q[k]  <= 1'b0;
            sum_q[k] <= '0;
            opa_q[k] <= '0;
            opb_q[k] <= '0;
         end else if (adv) begin
            vld_q[k] <= vi;
            cy_q[k]  <= c[CHUNK];
            sum_q[k] <= sum_d;
            opa_q[k] <= sa;
            opb_q[k] <= sb;
         end
      end

      // Only the top segment sees the carry into the MSB.
      if (k == STAGES - 1) begin : g_msb
         always_ff @(posedge clk) begin
            if (rst) begin
               cmsb_q <= 1'b0;
            end else if (adv) begin
               cmsb_q <= c[CHUNK-1];
            end
         end
      end
   end

   assign out_valid = vld_q[STAGES-1];
   assign sum       = sum_q[STAGES-1];
   assign cout      = cy_q[STAGES-1];
   assign ovf       = cy_q[STAGES-1] ^ cmsb_q;

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Directed table plus corner sequences on an 8-bit/2-stage instance; random
// regression against a reference model on a 32-bit/4-stage instance.
module tb_pipelined_ripple_adder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
   logic [7:0] a, b, sum;

   logic        r_in_valid, r_in_ready, r_cin, r_sub, r_out_valid, r_out_ready, r_cout, r_ovf;
   logic [31:0] r_a, r_b, r_sum;

   pipelined_ripple_adder #(.WIDTH(8), .STAGES(2)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
      .cout(cout), .ovf(ovf)
   );

   pipelined_ripple_adder #(.WIDTH(32), .STAGES(4)) u_dut32 (
      .clk(clk), .rst(rst), .in_valid(r_in_valid), .in_ready(r_in_ready), .a(r_a), .b(r_b),
      .cin(r_cin), .sub(r_sub), .out_valid(r_out_valid), .out_ready(r_out_ready), .sum(r_sum),
      .cout(r_cout), .ovf(r_ovf)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Returns {ovf, cout, sum[31:0]} using sign-based overflow rather than carries.
   function automatic logic [33:0] model(input int w, input logic [31:0] x, input logic [31:0] y,
                                         input logic ci, input logic sb);
      logic [32:0] full;
      logic [31:0] mask, yy, s;
      logic        co, ov;
      mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
      yy   = (sb ? ~y : y) & mask;
      full = {1'b0, x & mask} + {1'b0, yy} + {32'b0, sb ^ ci};
      s    = full[31:0] & mask;
      co   = full[w];
      ov   = (x[w-1] == yy[w-1]) && (s[w-1] != x[w-1]);
      return {ov, co, s};
   endfunction

   typedef struct {
      logic [7:0] a, b;
      logic       cin, sub;
      logic [7:0] s;
      logic       co, ov;
   } vec_t;

   vec_t        vecs [11];
   logic [7:0]  bp_a [5];
   logic [7:0]  bp_b [5];
   logic        bp_sub [5];
   logic        bp_cin [5];
   logic [33:0] bp_exp [5];
   logic [33:0] q [$];
   logic [33:0] e;

   task automatic pop_check32();
      if (r_out_valid && r_out_ready) begin
         if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rand_unexpected: got result %0h expected none", r_sum);
         end else begin
            e = q.pop_front();
            check("rand_result", {r_ovf, r_cout, r_sum}, e);
         end
      end
   endtask

   initial begin
      int idx, got;
      logic acc, stale;

      vecs[0]  = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
      vecs[1]  = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
      vecs[2]  = '{8'h80, 8'h80, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1};
      vecs[3]  = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
      vecs[4]  = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
      vecs[5]  = '{8'h10, 8'h01, 1'b1, 1'b1, 8'h0E, 1'b1, 1'b0};
      vecs[6]  = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
      vecs[7]  = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
      vecs[8]  = '{8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
      vecs[9]  = '{8'h3C, 8'h5A, 1'b1, 1'b0, 8'h97, 1'b0, 1'b1};
      vecs[10] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      r_in_valid = 1'b0; r_out_ready = 1'b1; r_a = '0; r_b = '0; r_cin = 1'b0; r_sub = 1'b0;

      @(posedge clk);
      @(negedge clk);
      check("in_ready_in_reset", in_ready, 1'b1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_sum", sum, 8'h00);
      check("rst_cout", cout, 1'b0);
      check("rst_ovf", ovf, 1'b0);
      check("rst_in_ready", in_ready, 1'b1);
      @(posedge clk); #1;

      // Directed vectors, one at a time, checking latency and value.
      out_ready = 1'b1;
      for (int i = 0; i < 11; i++) begin
         a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin; sub = vecs[i].sub;
         in_valid = 1'b1;
         @(posedge clk); #1;
         in_valid = 1'b0;
         @(negedge clk);
         check($sformatf("vec%0d_early", i), out_valid, 1'b0);
         @(posedge clk);
         @(negedge clk);
         check($sformatf("vec%0d_valid", i), out_valid, 1'b1);
         check($sformatf("vec%0d_sum", i), sum, vecs[i].s);
         check($sformatf("vec%0d_cout", i), cout, vecs[i].co);
         check($sformatf("vec%0d_ovf", i), ovf, vecs[i].ov);
         @(posedge clk); #1;
      end

      // Backpressure: five ops offered with the consumer stalled.
      for (int i = 0; i < 5; i++) begin
         bp_a[i]   = 8'h11 * 8'(i + 1);
         bp_b[i]   = 8'h2F + 8'(i);
         bp_sub[i] = i[0];
         bp_cin[i] = i[1];
         bp_exp[i] = model(8, {24'b0, bp_a[i]}, {24'b0, bp_b[i]}, bp_cin[i], bp_sub[i]);
      end
      out_ready = 1'b0;
      idx = 0;
      for (int cyc = 0; cyc < 5; cyc++) begin
         a = bp_a[idx]; b = bp_b[idx]; sub = bp_sub[idx]; cin = bp_cin[idx]; in_valid = 1'b1;
         @(negedge clk);
         acc = in_ready;
         if (cyc >= 2) begin
            check($sformatf("bp_hold%0d_valid", cyc), out_valid, 1'b1);
            check($sformatf("bp_hold%0d_in_ready", cyc), in_ready, 1'b0);
            check($sformatf("bp_hold%0d_result", cyc), {ovf, cout, sum}, {bp_exp[0][33:32], bp_exp[0][7:0]});
         end
         @(posedge clk); #1;
         if (acc) idx++;
      end
      check("bp_accepts", idx, 2);

      out_ready = 1'b1;
      got = 0;
      for (int cyc = 0; cyc < 12 && got < 5; cyc++) begin
         if (idx < 5) begin
            a = bp_a[idx]; b = bp_b[idx]; sub = bp_sub[idx]; cin = bp_cin[idx]; in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         check($sformatf("drain%0d_in_ready", cyc), in_ready, 1'b1);
         check($sformatf("drain%0d_valid", cyc), out_valid, 1'b1);
         if (out_valid) begin
            check($sformatf("drain_result%0d", got), {ovf, cout, sum},
                  {bp_exp[got][33:32], bp_exp[got][7:0]});
            got++;
         end
         acc = in_valid & in_ready;
         @(posedge clk); #1;
         if (acc) idx++;
      end
      check("drain_count", got, 5);
      check("drain_accepts", idx, 5);
      in_valid = 1'b0;
      @(posedge clk); #1;

      // Reset with two operations in flight and a third offered in the reset cycle.
      a = 8'h12; b = 8'h34; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      a = 8'hF0; b = 8'h0F;
      @(posedge clk); #1;
      rst = 1'b1; a = 8'h55;
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      check("midrst_valid", out_valid, 1'b0);
      check("midrst_sum", sum, 8'h00);
      check("midrst_cout", cout, 1'b0);
      check("midrst_ovf", ovf, 1'b0);
      stale = 1'b0;
      for (int cyc = 0; cyc < 4; cyc++) begin
         @(negedge clk);
         stale = stale | out_valid;
      end
      check("midrst_no_stale", stale, 1'b0);
      @(posedge clk); #1;

      // Random regression on the 32-bit, 4-stage instance.
      for (int cyc = 0; cyc < 400; cyc++) begin
         r_in_valid  = ($urandom_range(0, 3) != 0);
         r_out_ready = ($urandom_range(0, 9) < 7);
         r_a = $urandom; r_b = $urandom;
         r_cin = 1'($urandom_range(0, 1)); r_sub = 1'($urandom_range(0, 1));
         @(negedge clk);
         pop_check32();
         if (r_in_valid && r_in_ready) q.push_back(model(32, r_a, r_b, r_cin, r_sub));
         @(posedge clk); #1;
      end
      r_in_valid  = 1'b0;
      r_out_ready = 1'b1;
      for (int cyc = 0; cyc < 20 && q.size() > 0; cyc++) begin
         @(negedge clk);
         pop_check32();
         @(posedge clk); #1;
      end
      check("rand_drained", q.size(), 0);
      @(negedge clk);
      check("rand_idle", r_out_valid, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipelined_ripple_adder.md
# pipelined_ripple_adder

Parametrised, pipelined successor to the fixed 8-bit ripple-carry adder. It splits a WIDTH-bit ripple-carry chain into STAGES equal segments, with a register stage between segments. It supports add and subtract modes, carry/borrow in, carry out and signed overflow, behind a valid/ready handshake with backpressure. It sits in the datapath wherever the flat combinational adder limits timing at larger widths.

## Interface
- WIDTH, default 32: operand width in bits; must be divisible by STAGES.
- STAGES, default 4: number of pipeline stages, between 1 and WIDTH. CHUNK = WIDTH/STAGES bits are resolved per stage.
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in in add mode; borrow-in in subtract mode.
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry-out. In subtract mode it is the inverted borrow: 1 means no borrow.
- ovf  output  1  two's-complement signed overflow.

## Operation
- Effective operands:
  - bb = sub ? ~b : b.
  - c0 = sub ? ~cin : cin.
  - Add computes a + b + cin; subtract computes a - b - cin.
- Stage k (k = 0..STAGES-1) resolves bits [k*CHUNK +: CHUNK]:
  - It uses per-bit p = a^bb and g = a&bb, and a serial ripple g_i | p_i&c_i.
  - Its carry-in is the carry registered from stage k-1, or c0 for stage 0.
- Each stage register holds:
  - the valid bit;
  - the sum bits resolved so far;
  - the unresolved a/bb bits still to be processed (skew, so upper bits travel with their own operation);
  - the segment carry-out;
  - the carry into bit WIDTH-1 (needed only in the last stage).
- Final outputs:
  - cout = carry out of bit WIDTH-1.
  - ovf = carry into MSB XOR carry out of MSB, in both modes.
- All arithmetic is modulo 2^WIDTH; no sign extension is performed.
- Pipeline control is a global advance:
  - adv = !out_valid | out_ready.
  - in_ready = adv.
  - An operation is accepted when in_valid & in_ready.
- When adv = 1, every stage shifts forward by one, and bubbles (valid = 0) shift as well.
- When adv = 0, all stage registers hold, including data on bubble stages. No bubble collapsing occurs.
- The last-stage register drives sum, cout, ovf and out_valid directly.
- Reset clears every stage valid bit and every data register to 0. Any operation in flight when rst is sampled high is discarded.

## Timing
- Reset values:
  - out_valid = 0, sum = 0, cout = 0, ovf = 0.
  - in_ready = 1 from the first cycle after reset. It is combinational, so it is also 1 during reset.
- Latency: an operation accepted at edge N appears with out_valid = 1 after edge N+STAGES-1. With STAGES = 1 it is visible in the cycle following acceptance.
- Throughput: one operation per cycle while out_ready = 1.
- Capacity: at most STAGES operations in flight.
- Backpressure:
  - out_valid = 1 & out_ready = 0 forces in_ready = 0 in the same cycle.
  - sum, cout and ovf are stable and unchanged until the handshake completes.
- Simultaneous pop and push (out_valid & out_ready & in_valid): the result is consumed and the new operand is accepted on the same edge.
- in_valid = 0 while adv = 1 inserts a bubble; out_valid is 0 when that bubble reaches the last stage.
- rst takes priority over all handshakes; accepts and pops in a reset cycle have no effect.
- Boundary conditions:
  - Carry across a segment boundary (for example, all-ones plus 1) must propagate through all STAGES without any extra cycle.
  - The critical path is CHUNK bits of ripple plus register setup.

## Test plan
Use WIDTH = 8 and STAGES = 2 unless stated.
- Reset, then a=0xFF, b=0x01, cin=0, sub=0 -> after 1 extra cycle: sum=0x00, cout=1, ovf=0. The carry crosses the segment boundary.
- Add overflow and carry-in:
  - a=0x7F, b=0x01, add -> sum=0x80, cout=0, ovf=1.
  - a=0x80, b=0x80, cin=1 -> sum=0x01, cout=1, ovf=1.
- Subtract:
  - a=0x05, b=0x07, sub=1, cin=0 -> sum=0xFE, cout=0, ovf=0.
  - a=0x80, b=0x01, sub=1 -> sum=0x7F, cout=1, ovf=1.
  - a=0x10, b=0x01, sub=1, cin=1 -> sum=0x0E, cout=1.
- Backpressure:
  - Stream 5 back-to-back ops with out_ready=0 -> in_ready drops after 2 accepts, outputs are held stable, and no ops are lost.
  - Release out_ready -> results drain in order at 1 per cycle, with in_ready=1 throughout the drain.
- Reset mid-stream with 2 ops in flight -> next cycle out_valid=0, sum=0, cout=0, ovf=0, and no stale result ever appears.
- Random regression: STAGES in {1,2,4,8} with WIDTH=32, random valid/ready/sub/cin -> every result matches a reference model, in order, with latency STAGES cycles.
